// File: rtl/stage_sequencer.sv
// Multi-cycle sequencer that drives the fetch/decode/execute/memory/writeback handshakes and owns the PC.
// Optional feature macro: SEQ_INSTRET_EN (64-bit retired-instruction counter on instret).
module stage_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        run,
  input  logic        fetch_done,
  input  logic        decode_done,
  input  logic        exec_done,
  input  logic        mem_done,
  input  logic        wb_done,
  input  logic        need_mem,
  input  logic        halt_req,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        fetch_en,
  output logic        decode_en,
  output logic        exec_en,
  output logic        mem_en,
  output logic        wb_en,
  output logic [31:0] pc,
  output logic        halted,
  output logic        err,
  output logic [63:0] instret
);

  typedef enum logic [3:0] {
    IDLE, F_ISS, F_WAIT, D_ISS, D_WAIT, E_ISS, E_WAIT,
    M_ISS, M_WAIT, W_ISS, W_WAIT, HALT, ERROR
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  logic [7:0]  wait_cnt;
  logic        mem_q;
  logic        halt_q;
  logic        br_taken_q;
  logic [31:0] br_target_q;
  logic        wait_expired;

  // The counter holds the number of wait cycles already spent, so the final permitted one is TIMEOUT-1.
  assign wait_expired = (wait_cnt == WAIT_LAST);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= IDLE;
      fetch_en    <= 1'b0;
      decode_en   <= 1'b0;
      exec_en     <= 1'b0;
      mem_en      <= 1'b0;
      wb_en       <= 1'b0;
      pc          <= RESET_PC;
      halted      <= 1'b0;
      err         <= 1'b0;
      wait_cnt    <= '0;
      mem_q       <= 1'b0;
      halt_q      <= 1'b0;
      br_taken_q  <= 1'b0;
      br_target_q <= '0;
    end else begin
      // NOTE: non-blocking defaults first; a transition below overrides the one pulse it needs.
      fetch_en  <= 1'b0;
      decode_en <= 1'b0;
      exec_en   <= 1'b0;
      mem_en    <= 1'b0;
      wb_en     <= 1'b0;
      case (state)
        IDLE:  if (run) begin state <= F_ISS; fetch_en <= 1'b1; end
        F_ISS: begin state <= F_WAIT; wait_cnt <= '0; end
        D_ISS: begin state <= D_WAIT; wait_cnt <= '0; end
        E_ISS: begin state <= E_WAIT; wait_cnt <= '0; end
        M_ISS: begin state <= M_WAIT; wait_cnt <= '0; end
        W_ISS: begin state <= W_WAIT; wait_cnt <= '0; end
        F_WAIT: begin
          if (fetch_done)        begin state <= D_ISS; decode_en <= 1'b1; end
          else if (wait_expired) begin state <= ERROR; err <= 1'b1; end
          else                   wait_cnt <= wait_cnt + 8'd1;
        end
        D_WAIT: begin
          if (decode_done) begin
            mem_q     <= need_mem;
            halt_q    <= halt_req;
            state     <= E_ISS;
            exec_en   <= 1'b1;
          end
          else if (wait_expired) begin state <= ERROR; err <= 1'b1; end
          else                   wait_cnt <= wait_cnt + 8'd1;
        end
        E_WAIT: begin
          if (exec_done) begin
            br_taken_q  <= branch_taken;
            br_target_q <= branch_target;
            if (branch_taken && branch_target[1:0] != 2'b00) begin
              state <= ERROR;
              err   <= 1'b1;
            end else if (mem_q) begin
              state  <= M_ISS;
              mem_en <= 1'b1;
            end else begin
              state <= W_ISS;
              wb_en <= 1'b1;
            end
          end
          else if (wait_expired) begin state <= ERROR; err <= 1'b1; end
          else                   wait_cnt <= wait_cnt + 8'd1;
        end
        M_WAIT: begin
          if (mem_done)          begin state <= W_ISS; wb_en <= 1'b1; end
          else if (wait_expired) begin state <= ERROR; err <= 1'b1; end
          else                   wait_cnt <= wait_cnt + 8'd1;
        end
        W_WAIT: begin
          if (wb_done) begin
            pc <= br_taken_q ? br_target_q : pc + 32'd4;
            if (halt_q) begin
              state  <= HALT;
              halted <= 1'b1;
            end else begin
              state    <= F_ISS;
              fetch_en <= 1'b1;
            end
          end
          else if (wait_expired) begin state <= ERROR; err <= 1'b1; end
          else                   wait_cnt <= wait_cnt + 8'd1;
        end
        HALT, ERROR: ;
        default: begin state <= ERROR; err <= 1'b1; end
      endcase
    end
  end

`ifdef SEQ_INSTRET_EN
  always_ff @(posedge clk) begin
    if (!rstn)                         instret <= '0;
    else if (state == W_WAIT && wb_done) instret <= instret + 64'd1;
  end
`else
  assign instret = '0;
`endif

endmodule

// File: tb/tb_stage_sequencer.sv
// Randomized bench for stage_sequencer: a transaction-level model predicts the cycle of every stage pulse, the PC and the status flags.
module tb_stage_sequencer;

  localparam int          TMO = 4;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        run = 1'b0;
  logic [4:0]  done_v = '0;
  logic        need_mem = 1'b0;
  logic        halt_req = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        fetch_en, decode_en, exec_en, mem_en, wb_en;
  logic [31:0] pc;
  logic        halted, err;
  logic [63:0] instret;

  int n_vec = 0;
  int n_bad = 0;

  // Model of the architectural state and of the instruction currently being sequenced.
  logic [31:0] m_pc;
  logic [63:0] m_instret;
  bit          cur_mem, cur_halt, cur_taken;
  logic [31:0] cur_tgt;
  int          fixed_d = 0;
  int          e_d = 0;
  bit          hold_decode = 1'b0;

  stage_sequencer #(.RESET_PC(RPC), .TIMEOUT(TMO)) dut (
    .clk(clk), .rstn(rstn), .run(run),
    .fetch_done(done_v[0]), .decode_done(done_v[1]), .exec_done(done_v[2]),
    .mem_done(done_v[3]), .wb_done(done_v[4]),
    .need_mem(need_mem), .halt_req(halt_req),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .fetch_en(fetch_en), .decode_en(decode_en), .exec_en(exec_en),
    .mem_en(mem_en), .wb_en(wb_en),
    .pc(pc), .halted(halted), .err(err), .instret(instret)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cycle_begin();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_junk();
    run           = 1'($urandom);
    done_v        = 5'($urandom);
    need_mem      = 1'($urandom);
    halt_req      = 1'($urandom);
    branch_taken  = 1'($urandom);
    branch_target = $urandom;
    if (hold_decode) done_v[1] = 1'b1;
  endtask

  task automatic sample_check(input string tag, input logic [4:0] exp_en,
                              input bit exp_halt, input bit exp_err);
    logic [63:0] exp_ir;
`ifdef SEQ_INSTRET_EN
    exp_ir = m_instret;
`else
    exp_ir = '0;
`endif
    @(negedge clk);
    check({tag, ".en"}, {59'b0, wb_en, mem_en, exec_en, decode_en, fetch_en}, {59'b0, exp_en});
    check({tag, ".pc"}, {32'b0, pc}, {32'b0, m_pc});
    check({tag, ".halted"}, {63'b0, halted}, {63'b0, exp_halt});
    check({tag, ".err"}, {63'b0, err}, {63'b0, exp_err});
    check({tag, ".instret"}, instret, exp_ir);
  endtask

  // Entered at the start of the ISS cycle; returns after sampling the last WAIT cycle.
  // res: 0 handshake, 1 timeout, 2 reset asserted.
  task automatic do_stage(input int s, input int d, input int rst_at, output int res);
    drive_junk();
    sample_check("iss", 5'(1 << s), 1'b0, 1'b0);
    for (int k = 1; k <= TMO; k++) begin
      cycle_begin();
      drive_junk();
      done_v[s] = (k == d);
      if (hold_decode) done_v[1] = 1'b1;
      if (k == d && s == 1) begin need_mem = cur_mem; halt_req = cur_halt; end
      if (k == d && s == 2) begin branch_taken = cur_taken; branch_target = cur_tgt; end
      if (k == rst_at) rstn = 1'b0;
      sample_check("wait", 5'b0, 1'b0, 1'b0);
      if (k == rst_at) begin res = 2; return; end
      if (k == d) begin res = 0; return; end
    end
    res = 1;
  endtask

  function automatic int pick_d(input int s);
    if (e_d != 0 && s == 2) return e_d;
    if (fixed_d != 0) return fixed_d;
    return $urandom_range(1, TMO);
  endfunction

  // outcome: 0 next fetch, 1 halted, 2 error, 3 reset taken mid-instruction.
  task automatic run_instr(input int to_stage, input int rst_stage, output int outcome);
    int d, ra, res;
    for (int s = 0; s < 5; s++) begin
      if (s == 3 && !cur_mem) continue;
      d  = pick_d(s);
      ra = 0;
      if (s == to_stage) d = TMO + 1;
      if (s == rst_stage) begin d = TMO; ra = $urandom_range(1, TMO); end
      do_stage(s, d, ra, res);
      cycle_begin();
      if (res == 1) begin outcome = 2; return; end
      if (res == 2) begin outcome = 3; return; end
      if (s == 2 && cur_taken && cur_tgt[1:0] != 2'b00) begin outcome = 2; return; end
    end
    m_pc      = cur_taken ? cur_tgt : m_pc + 32'd4;
    m_instret = m_instret + 64'd1;
    outcome   = cur_halt ? 1 : 0;
  endtask

  task automatic set_instr(input bit mem, input bit halt, input bit taken, input logic [31:0] tgt);
    cur_mem = mem; cur_halt = halt; cur_taken = taken; cur_tgt = tgt;
  endtask

  // Reset, hold IDLE for one cycle with run low, then request run; ends at the start of F_ISS.
  task automatic do_reset();
    drive_junk();
    rstn = 1'b0;
    cycle_begin();
    drive_junk();
    rstn = 1'b1;
    run  = 1'b0;
    m_pc = RPC;
    m_instret = '0;
    sample_check("reset", 5'b0, 1'b0, 1'b0);
    cycle_begin();
    drive_junk();
    run = 1'b1;
    sample_check("idle", 5'b0, 1'b0, 1'b0);
    cycle_begin();
  endtask

  // Called in the cycle after a mid-instruction reset edge, with run held high.
  task automatic after_reset();
    m_pc = RPC;
    m_instret = '0;
    drive_junk();
    rstn = 1'b1;
    run  = 1'b1;
    sample_check("rst_mid", 5'b0, 1'b0, 1'b0);
    cycle_begin();
  endtask

  task automatic check_absorb(input int n, input bit h, input bit e);
    for (int i = 0; i < n; i++) begin
      drive_junk();
      sample_check("absorb", 5'b0, h, e);
      cycle_begin();
    end
  endtask

  initial begin
    int oc, to, rs;

    // ALU op then load, minimum latency on every stage.
    do_reset();
    fixed_d = 1;
    set_instr(1'b0, 1'b0, 1'b0, 32'h0);      run_instr(-1, -1, oc);
    set_instr(1'b1, 1'b0, 1'b0, 32'h0);      run_instr(-1, -1, oc);
    // Taken branch, then a fetch from the target, then a misaligned target.
    set_instr(1'b0, 1'b0, 1'b1, 32'h100);    run_instr(-1, -1, oc);
    set_instr(1'b0, 1'b0, 1'b0, 32'h0);      run_instr(-1, -1, oc);
    set_instr(1'b0, 1'b0, 1'b1, 32'h102);    run_instr(-1, -1, oc);
    check_absorb(4, 1'b0, 1'b1);

    // PC wrap-around past the top of the address space.
    do_reset();
    set_instr(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC); run_instr(-1, -1, oc);
    set_instr(1'b1, 1'b0, 1'b0, 32'h0);         run_instr(-1, -1, oc);
    run_instr(-1, -1, oc);

    // Halt with decode_done stuck high.
    do_reset();
    hold_decode = 1'b1;
    set_instr(1'b0, 1'b1, 1'b0, 32'h0);      run_instr(-1, -1, oc);
    hold_decode = 1'b0;
    check_absorb(5, 1'b1, 1'b0);

    // Execute timeout, then exec_done on the last permitted wait cycle.
    do_reset();
    set_instr(1'b0, 1'b0, 1'b0, 32'h0);      run_instr(2, -1, oc);
    check_absorb(3, 1'b0, 1'b1);
    do_reset();
    e_d = TMO;
    run_instr(-1, -1, oc);
    run_instr(-1, -1, oc);
    e_d = 0;

    // Reset while the memory stage is waiting.
    set_instr(1'b1, 1'b0, 1'b0, 32'h0);      run_instr(-1, 3, oc);
    after_reset();
    set_instr(1'b0, 1'b0, 1'b0, 32'h0);      run_instr(-1, -1, oc);

    // Random campaign.
    fixed_d = 0;
    for (int n = 0; n < 250; n++) begin
      cur_mem   = 1'($urandom_range(0, 1));
      cur_halt  = ($urandom_range(0, 19) == 0);
      cur_taken = ($urandom_range(0, 2) == 0);
      cur_tgt   = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 15) == 0) cur_tgt[1:0] = 2'($urandom_range(1, 3));
      to = ($urandom_range(0, 24) == 0) ? int'($urandom_range(0, 4)) : -1;
      rs = ($urandom_range(0, 24) == 0) ? int'($urandom_range(0, 4)) : -1;
      run_instr(to, rs, oc);
      case (oc)
        1: begin check_absorb(3, 1'b1, 1'b0); do_reset(); end
        2: begin check_absorb(3, 1'b0, 1'b1); do_reset(); end
        3: after_reset();
        default: ;
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
